ram_dump_tx: RTL and testbench
==============================

Name: ram_dump_tx

Overview:
- Readout end of the CPU data-RAM write path. The CPU writes the eight 4-bit RAM cells (r0..r7); this block reads them out to a host.
- On request it snapshots all eight cells and serialises them as a UART (8N1) packet on a single Tx line.
- Sits beside the CPU top. It taps the r0..r7 output buses and drives a board pin, giving the host a view of program results without stopping the CPU.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit; legal range 2..65535.
- HEADER, 8'hA5, sync byte sent first in every packet.

Ports:
- Clock  input  1  system clock; all state changes on rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Start  input  1  request a dump; sampled each rising edge.
- Mem  input  32  RAM snapshot source; Mem[4k+3:4k] = rk, k = 0..7.
- Tx  output  1  UART serial out; idles high.
- Busy  output  1  high while a packet is being transmitted.
- Done  output  1  one-cycle pulse when a packet completes.

Behaviour:
- Reset (Reset_n = 0, asynchronous):
  - Tx = 1, Busy = 0, Done = 0.
  - FSM returns to IDLE; bit counter, byte index and baud counter clear to 0; snapshot register clears to 0.
- Reset asserted mid-packet: Tx returns to 1 immediately (no glitch low), the packet is abandoned, and no Done pulse is produced.
- Packet format, 6 bytes in order:
  1. HEADER.
  2. {r1,r0}.
  3. {r3,r2}.
  4. {r5,r4}.
  5. {r7,r6}.
  6. CHK = XOR of bytes 2..5; the header is excluded.
- Each byte is framed as: start bit (0), 8 data bits LSB first, stop bit (1). Each bit is held for exactly CLKS_PER_BIT cycles.
- Frames are back-to-back with no idle gap between a stop bit and the next start bit.
- Total packet length is 60*CLKS_PER_BIT cycles.
- FSM states: IDLE, START_BIT, DATA_BITS, STOP_BIT.
  - IDLE -> START_BIT when Start = 1 at edge T.
    - Mem is captured into the snapshot register at edge T.
    - CHK is computed from the snapshot, never from live Mem.
  - START_BIT -> DATA_BITS after CLKS_PER_BIT cycles.
  - DATA_BITS -> STOP_BIT after 8*CLKS_PER_BIT cycles; the bit index increments every CLKS_PER_BIT cycles.
  - STOP_BIT -> START_BIT (next byte) after CLKS_PER_BIT cycles if the byte index is below 5; otherwise STOP_BIT -> IDLE.
- Latency and handshake timing:
  - Tx falls and Busy rises in the cycle after edge T.
  - Busy stays high through the final stop bit.
  - On the cycle Busy deasserts, Done = 1 for exactly one cycle.
- Start while Busy = 1 is ignored and not queued.
- Start held high continuously: a new packet begins on the edge immediately after Done; Busy drops for that one Done cycle only.
- Mem changing during a packet has no effect on the packet in flight.
- The baud counter wraps from CLKS_PER_BIT-1 to 0 and is sized to hold CLKS_PER_BIT-1.
- Tx is a registered output and must be glitch-free.

Test Plan:
- Reset: hold Reset_n = 0 for 5 cycles -> Tx = 1, Busy = 0, Done = 0. Then release with Start = 0 for 100 cycles -> Tx stays 1.
- Basic dump: CLKS_PER_BIT = 16, Mem = 32'h87654321, pulse Start for 1 cycle.
  - Tx carries bytes A5, 21, 43, 65, 87, 80, decoded by a bench UART.
  - Busy is high for exactly 960 cycles.
  - Done pulses once, on cycle 961 after the Start edge.
- Snapshot stability: start with Mem = 32'h00000000, then change Mem to 32'hFFFFFFFF on cycle 50 -> bytes received are A5, 00, 00, 00, 00, 00.
- Start while busy: pulse Start again at cycle 300 of a packet -> exactly one packet is sent and Done pulses once.
- Continuous Start: hold Start = 1 across two packets with Mem = 32'h0F0F0F0F.
  - Two packets A5, 0F, 0F, 0F, 0F, 00 are sent.
  - A single-cycle gap with Tx = 1 and Busy = 0 separates them, coinciding with Done.
- Reset mid-packet: assert Reset_n = 0 asynchronously during a data-bit-0 period.
  - Tx goes high the same instant; Busy = 0; no Done.
  - A following Start produces a complete, correct packet.

Source files
------------

// File: rtl/ram_dump_tx.sv
// ram_dump_tx: snapshots the eight 4-bit RAM cells and sends them to a host
// as a 6-byte 8N1 UART packet (header, four data bytes, XOR checksum).
module ram_dump_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter logic [7:0]  HEADER       = 8'hA5
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic        Start,
    input  logic [31:0] Mem,
    output logic        Tx,
    output logic        Busy,
    output logic        Done
);

    localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0] LAST_BYTE = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        START_BIT,
        DATA_BITS,
        STOP_BIT
    } state_e;

    state_e        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [2:0]    byte_q, byte_d;
    logic [31:0]   snap_q, snap_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          tick;
    logic [7:0]    cur_byte;

    // Packet byte by index; the checksum is always derived from the snapshot.
    function automatic logic [7:0] pkt_byte(input logic [2:0] idx,
                                            input logic [31:0] s);
        logic [7:0] b;
        unique case (idx)
            3'd0:    b = HEADER;
            3'd1:    b = s[7:0];
            3'd2:    b = s[15:8];
            3'd3:    b = s[23:16];
            3'd4:    b = s[31:24];
            default: b = s[7:0] ^ s[15:8] ^ s[23:16] ^ s[31:24];
        endcase
        return b;
    endfunction

    assign tick = (baud_q == BAUD_MAX);

    // Next-state logic: FSM, baud/bit/byte counters, snapshot and outputs.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        snap_d   = snap_q;
        done_d   = 1'b0;
        tx_d     = 1'b1;
        busy_d   = 1'b0;
        cur_byte = 8'h00;

        if (state_q != IDLE) begin
            baud_d = tick ? '0 : baud_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d = START_BIT;
                    snap_d  = Mem;
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    byte_d  = 3'd0;
                end
            end
            START_BIT: begin
                if (tick) begin
                    state_d = DATA_BITS;
                    bit_d   = 3'd0;
                end
            end
            DATA_BITS: begin
                if (tick) begin
                    if (bit_q == 3'd7) begin
                        state_d = STOP_BIT;
                        bit_d   = 3'd0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            STOP_BIT: begin
                if (tick) begin
                    if (byte_q < LAST_BYTE) begin
                        state_d = START_BIT;
                        byte_d  = byte_q + 3'd1;
                    end else begin
                        state_d = IDLE;
                        byte_d  = 3'd0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cur_byte = pkt_byte(byte_d, snap_d);
        busy_d   = (state_d != IDLE);

        unique case (state_d)
            START_BIT: tx_d = 1'b0;
            DATA_BITS: tx_d = cur_byte[bit_d];
            default:   tx_d = 1'b1;
        endcase
    end

    // State and output registers; reset forces the line idle at once.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            byte_q  <= 3'd0;
            snap_q  <= 32'h0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            snap_q  <= snap_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Tx   = tx_q;
    assign Busy = busy_q;
    assign Done = done_q;

endmodule

// File: tb/tb_ram_dump_tx.sv
// tb_ram_dump_tx: table-driven packets decoded by a bench UART receiver,
// with expected bytes queued at stimulus time and popped on reception.
module tb_ram_dump_tx;

    localparam int CPB = 16;
    localparam int PKT = 60 * CPB;

    logic        Clock = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Start = 1'b0;
    logic [31:0] Mem = 32'h0;
    logic        Tx;
    logic        Busy;
    logic        Done;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] exp_q[$];

    typedef struct {
        logic [31:0] mem;
        logic [31:0] mem_late;
        int          late_at;
        int          restart_at;
        logic [47:0] bytes;
    } vec_t;

    vec_t tbl[5];

    ram_dump_tx #(.CLKS_PER_BIT(CPB), .HEADER(8'hA5)) dut (
        .Clock  (Clock),
        .Reset_n(Reset_n),
        .Start  (Start),
        .Mem    (Mem),
        .Tx     (Tx),
        .Busy   (Busy),
        .Done   (Done)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bench UART receiver, sampling mid-bit on the falling edge.
    int         rx_cnt = 0;
    bit         rx_act = 0;
    logic [7:0] rx_sh = 8'h0;
    logic [7:0] rx_exp;

    always @(negedge Clock) begin
        if (!Reset_n) begin
            rx_act = 0;
            rx_cnt = 0;
        end else if (!rx_act) begin
            if (Tx == 1'b0) begin
                rx_act = 1;
                rx_cnt = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt >= 24 && rx_cnt <= 136 && ((rx_cnt - 24) % CPB) == 0)
                rx_sh[(rx_cnt - 24) / CPB] = Tx;
            if (rx_cnt == 152) begin
                rx_act = 0;
                n_cmp++;
                if (Tx !== 1'b1) begin
                    n_bad++;
                    $display("FAIL rx_stop: got %b expected 1", Tx);
                end
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL rx_extra: got %0h expected none", rx_sh);
                end else begin
                    rx_exp = exp_q.pop_front();
                    if (rx_sh !== rx_exp) begin
                        n_bad++;
                        $display("FAIL rx_byte: got %0h expected %0h",
                                 rx_sh, rx_exp);
                    end
                end
            end
        end
    end

    task automatic push_bytes(input logic [47:0] b);
        for (int i = 0; i < 6; i++) exp_q.push_back(b[8*(5-i) +: 8]);
    endtask

    task automatic run_pkt(input vec_t v);
        int busy_n;
        int done_n;
        int done_k;
        busy_n = 0;
        done_n = 0;
        done_k = 0;
        push_bytes(v.bytes);
        @(negedge Clock);
        Mem   = v.mem;
        Start = 1'b1;
        @(posedge Clock);
        for (int k = 1; k <= PKT + 15; k++) begin
            @(negedge Clock);
            if (k == 1) begin
                chk("tx_falls", {31'h0, Tx}, 32'd0);
                chk("busy_rises", {31'h0, Busy}, 32'd1);
            end
            if (Busy) busy_n++;
            if (Done) begin
                done_n++;
                done_k = k;
            end
            if (k == v.late_at) Mem = v.mem_late;
            Start = (k == v.restart_at);
        end
        chk("busy_len", busy_n, PKT);
        chk("done_at", done_k, PKT + 1);
        chk("done_cnt", done_n, 1);
        chk("q_drained", exp_q.size(), 0);
    endtask

    initial begin
        int busy_n;
        int done_n;
        int tx_low;

        tbl[0] = '{32'h87654321, 32'h87654321, 0, 0, 48'hA5_21_43_65_87_80};
        tbl[1] = '{32'h00000000, 32'hFFFFFFFF, 50, 0, 48'hA5_00_00_00_00_00};
        tbl[2] = '{32'h12345678, 32'h12345678, 0, 300, 48'hA5_78_56_34_12_08};
        tbl[3] = '{32'hDEADBEEF, 32'h00000000, 500, 0, 48'hA5_EF_BE_AD_DE_22};
        tbl[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 48'hA5_FF_FF_FF_FF_00};

        Reset_n = 1'b0;
        repeat (5) @(negedge Clock);
        chk("rst_tx", {31'h0, Tx}, 32'd1);
        chk("rst_busy", {31'h0, Busy}, 32'd0);
        chk("rst_done", {31'h0, Done}, 32'd0);
        Reset_n = 1'b1;
        tx_low = 0;
        repeat (100) begin
            @(negedge Clock);
            if (Tx !== 1'b1 || Busy !== 1'b0 || Done !== 1'b0) tx_low++;
        end
        chk("idle_quiet", tx_low, 0);

        for (int i = 0; i < 5; i++) run_pkt(tbl[i]);

        // Start held high across two packets.
        busy_n = 0;
        done_n = 0;
        push_bytes(48'hA5_0F_0F_0F_0F_00);
        push_bytes(48'hA5_0F_0F_0F_0F_00);
        @(negedge Clock);
        Mem   = 32'h0F0F0F0F;
        Start = 1'b1;
        @(posedge Clock);
        for (int k = 1; k <= 2 * PKT + 20; k++) begin
            @(negedge Clock);
            if (Busy) busy_n++;
            if (Done) done_n++;
            if (k == PKT + 1) begin
                chk("gap_tx", {31'h0, Tx}, 32'd1);
                chk("gap_busy", {31'h0, Busy}, 32'd0);
                chk("gap_done", {31'h0, Done}, 32'd1);
            end
            if (k == PKT + 2) chk("resume_busy", {31'h0, Busy}, 32'd1);
            if (k == 2 * PKT + 2) Start = 1'b0;
        end
        chk("cont_busy_len", busy_n, 2 * PKT);
        chk("cont_done_cnt", done_n, 2);
        chk("cont_q_drained", exp_q.size(), 0);

        // Asynchronous reset during data bit 0 of the first data byte.
        exp_q.push_back(8'hA5);
        @(negedge Clock);
        Mem   = 32'h00000000;
        Start = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        Start = 1'b0;
        repeat (179) @(negedge Clock);
        chk("pre_rst_tx", {31'h0, Tx}, 32'd0);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("mid_rst_tx", {31'h0, Tx}, 32'd1);
        chk("mid_rst_busy", {31'h0, Busy}, 32'd0);
        done_n = 0;
        tx_low = 0;
        repeat (3) @(negedge Clock);
        Reset_n = 1'b1;
        repeat (200) begin
            @(negedge Clock);
            if (Done) done_n++;
            if (Tx !== 1'b1 || Busy !== 1'b0) tx_low++;
        end
        chk("mid_rst_nodone", done_n, 0);
        chk("mid_rst_idle", tx_low, 0);
        chk("mid_rst_q", exp_q.size(), 0);

        run_pkt(tbl[3]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
